// File: rtl/bin2ascii_stream.sv
// Sequential binary-to-ASCII converter emitting a valid/ready byte stream (signed/unsigned, decimal/hex, zero pad).
// Optional CR/LF terminator enabled by defining BIN2ASCII_NEWLINE_EN.
module bin2ascii_stream #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned DEC_DIGITS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] binaryin,
  input  logic            is_signed,
  input  logic            hex_mode,
  input  logic            pad_zero,
  input  logic            start,
  output logic            busy,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            done
);

  localparam int unsigned HEX_DIGITS = (BITS + 3) / 4;
  localparam int unsigned MAXD       = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
  localparam int unsigned DW         = 4 * MAXD;
  localparam int unsigned IW         = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int unsigned CW         = $clog2(BITS + 2);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT_SIGN,
    EMIT_DIGIT,
    FINISH
`ifdef BIN2ASCII_NEWLINE_EN
    , EMIT_CR,
    EMIT_LF
`endif
  } state_t;

  state_t          state, state_d;
  logic [BITS-1:0] mag, mag_d;
  logic [DW-1:0]   digits, digits_d;
  logic            neg, neg_d, hex, hex_d, pad, pad_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IW-1:0]   idx, idx_d;
  logic [7:0]      tx_data_d;
  logic            tx_valid_d, busy_d, done_d;

  logic [DW-1:0]   dab;
  logic [IW-1:0]   lead, idx_m1;
  logic [3:0]      cur_digit, next_digit;
  logic            start_neg;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      digits   <= '0;
      neg      <= 1'b0;
      hex      <= 1'b0;
      pad      <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      mag      <= mag_d;
      digits   <= digits_d;
      neg      <= neg_d;
      hex      <= hex_d;
      pad      <= pad_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state, datapath updates and registered output values
  always_comb begin
    state_d    = state;
    mag_d      = mag;
    digits_d   = digits;
    neg_d      = neg;
    hex_d      = hex;
    pad_d      = pad;
    cnt_d      = cnt;
    idx_d      = idx;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    busy_d     = busy;
    done_d     = 1'b0;
    start_neg  = is_signed & binaryin[BITS-1];

    dab = digits;
    for (int unsigned i = 0; i < MAXD; i++) begin
      if (dab[4*i +: 4] >= 4'd5) dab[4*i +: 4] = dab[4*i +: 4] + 4'd3;
    end

    // Zero magnitude leaves lead at 0 so a single '0' is still emitted
    lead = '0;
    for (int unsigned i = 0; i < MAXD; i++) begin
      if (digits[4*i +: 4] != 4'd0) lead = IW'(i);
    end
    if (pad) lead = hex ? IW'(HEX_DIGITS - 1) : IW'(DEC_DIGITS - 1);

    idx_m1     = idx - IW'(1);
    cur_digit  = digits[{idx, 2'b00} +: 4];
    next_digit = digits[{idx_m1, 2'b00} +: 4];

    unique case (state)
      IDLE: begin
        if (start) begin
          neg_d    = start_neg;
          mag_d    = start_neg ? (~binaryin + BITS'(1)) : binaryin;
          hex_d    = hex_mode;
          pad_d    = pad_zero;
          digits_d = '0;
          cnt_d    = hex_mode ? CW'(2) : CW'(BITS + 1);
          busy_d   = 1'b1;
          state_d  = CONVERT;
        end
      end
      // cnt>1: conversion work, cnt==1: pick leading digit, cnt==0: present first byte
      CONVERT: begin
        if (cnt > CW'(1)) begin
          if (hex) begin
            digits_d = DW'(mag);
          end else begin
            digits_d = {dab[DW-2:0], mag[BITS-1]};
            mag_d    = mag << 1;
          end
          cnt_d = cnt - CW'(1);
        end else if (cnt == CW'(1)) begin
          idx_d = lead;
          cnt_d = '0;
        end else begin
          tx_valid_d = 1'b1;
          if (neg) begin
            state_d   = EMIT_SIGN;
            tx_data_d = 8'h2D;
          end else begin
            state_d   = EMIT_DIGIT;
            tx_data_d = to_ascii(cur_digit);
          end
        end
      end
      EMIT_SIGN: begin
        if (tx_ready) begin
          state_d   = EMIT_DIGIT;
          tx_data_d = to_ascii(cur_digit);
        end
      end
      EMIT_DIGIT: begin
        if (tx_ready) begin
          if (idx == '0) begin
`ifdef BIN2ASCII_NEWLINE_EN
            state_d   = EMIT_CR;
            tx_data_d = 8'h0D;
`else
            state_d    = FINISH;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
`endif
          end else begin
            idx_d     = idx_m1;
            tx_data_d = to_ascii(next_digit);
          end
        end
      end
`ifdef BIN2ASCII_NEWLINE_EN
      EMIT_CR: begin
        if (tx_ready) begin
          state_d   = EMIT_LF;
          tx_data_d = 8'h0A;
        end
      end
      EMIT_LF: begin
        if (tx_ready) begin
          state_d    = FINISH;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2ascii_stream.sv
// Scoreboard bench for bin2ascii_stream: directed requests push expected bytes, a negedge monitor pops and compares.
module tb_bin2ascii_stream;

  logic        clk;
  logic        rst;
  logic [31:0] binaryin;
  logic        is_signed;
  logic        hex_mode;
  logic        pad_zero;
  logic        start;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;

  bin2ascii_stream #(.BITS(32), .DEC_DIGITS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .binaryin (binaryin),
    .is_signed(is_signed),
    .hex_mode (hex_mode),
    .pad_zero (pad_zero),
    .start    (start),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic       stall_q = 1'b0;
  logic [7:0] held    = 8'h00;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold during stalls
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        chk(tx_valid && (tx_data == held), "stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_byte", {24'd0, tx_data}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(tx_data == e, "byte", {24'd0, tx_data}, {24'd0, e});
        end
      end
      stall_q = tx_valid && !tx_ready;
      held    = tx_data;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_msg(input string s);
    push_str(s);
`ifdef BIN2ASCII_NEWLINE_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic do_start(input logic [31:0] v, input bit s, input bit h, input bit p);
    binaryin  = v;
    is_signed = s;
    hex_mode  = h;
    pad_zero  = p;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat, input string name);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == exp_lat, name, 32'(n), 32'(exp_lat));
  endtask

  task automatic run_to_done(input bit bp);
    int n = 0;
    int extra = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (bp) begin
        tx_ready = 1'($urandom_range(0, 1));
        start    = busy && ($urandom_range(0, 3) == 0);
        binaryin = $urandom;
      end
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    chk(done && !busy && (exp_q.size() == 0), "done_end", {done, busy, 30'(exp_q.size())}, 32'h8000_0000);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk(extra == 0, "done_once", 32'(extra), 32'd0);
  endtask

  task automatic run(input logic [31:0] v, input bit s, input bit h, input bit p,
                     input string msg, input int lat, input bit bp);
    push_msg(msg);
    do_start(v, s, h, p);
    wait_valid(lat, "latency");
    run_to_done(bp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; binaryin = '0; is_signed = 1'b0;
    hex_mode = 1'b0; pad_zero = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({busy, tx_valid, done} == 3'b000, "reset_flags", {29'd0, busy, tx_valid, done}, 32'd0);
    chk(tx_data == 8'h00, "reset_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(32'd12345,      1'b0, 1'b0, 1'b0, "12345",       34, 1'b0);
    run(32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, "-1",          34, 1'b0);
    run(32'h8000_0000,  1'b1, 1'b0, 1'b0, "-2147483648", 34, 1'b0);
    run(32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0, "4294967295",  34, 1'b0);
    run(32'd42,         1'b0, 1'b0, 1'b1, "0000000042",  34, 1'b0);
    run(32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, "DEADBEEF",    3,  1'b0);
    run(32'h0000_001F,  1'b0, 1'b1, 1'b0, "1F",          3,  1'b0);
    run(32'h0000_001F,  1'b0, 1'b1, 1'b1, "0000001F",    3,  1'b0);
    run(32'h0000_0000,  1'b0, 1'b1, 1'b0, "0",           3,  1'b0);
    run(32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0, "-1",          3,  1'b0);
    run(32'd0,          1'b0, 1'b0, 1'b0, "0",           34, 1'b0);
    run(32'd907,        1'b0, 1'b0, 1'b0, "907",         34, 1'b1);
    run(32'd7,          1'b0, 1'b0, 1'b0, "7",           34, 1'b0);

    // Reset while the third byte of "12345" is stalled
    tx_ready = 1'b0;
    push_str("12");
    do_start(32'd12345, 1'b0, 1'b0, 1'b0);
    wait_valid(34, "latency_rst");
    tx_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    @(posedge clk); #1;
    chk(tx_valid && (tx_data == 8'h33), "stall_third", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h33});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({busy, tx_valid, done} == 3'b000, "rst_mid_flags", {29'd0, busy, tx_valid, done}, 32'd0);
    chk(exp_q.size() == 0, "rst_mid_queue", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    run(32'd42, 1'b0, 1'b0, 1'b0, "42", 34, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
